// File: rtl/fifo_ctrl.sv
// Pointer/occupancy controller that runs an external register file as a circular FIFO.
// Holds no data; the register file's combinational read port supplies out_data.
module fifo_ctrl #(
  parameter int wAddr = 2,
  parameter int wData = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [wData-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [wData-1:0] out_data,
  output logic [wAddr-1:0] rf_wa0,
  output logic [wData-1:0] rf_wd0,
  output logic             rf_we,
  output logic [wAddr-1:0] rf_ra0,
  input  logic [wData-1:0] rf_rd0,
  output logic [wAddr:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << wAddr;
  localparam logic [wAddr:0] DEPTH_C = (wAddr + 1)'(DEPTH);

  logic [wAddr-1:0] wr_ptr;
  logic [wAddr-1:0] rd_ptr;
  logic [wAddr:0]   count_q;
  logic             push;
  logic             pop;

  always_comb begin
    full      = (count_q == DEPTH_C);
    empty     = (count_q == '0);
    in_ready  = !full;
    out_valid = !empty;
    // Reset gates the write strobe so nothing lands in the register file while held.
    push      = in_valid && in_ready && !flush && reset;
    pop       = out_valid && out_ready && !flush;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  always_comb begin
    rf_wa0   = wr_ptr;
    rf_wd0   = in_data;
    rf_we    = push;
    rf_ra0   = rd_ptr;
    out_data = rf_rd0;
    count    = count_q;
  end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl: vector table of per-cycle stimulus and expected flags, with a
// data scoreboard fed on accepted pushes and drained on accepted pops.
module tb_fifo_ctrl;

  logic       clock;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic [1:0] rf_wa0;
  logic [3:0] rf_wd0;
  logic       rf_we;
  logic [1:0] rf_ra0;
  logic [3:0] rf_rd0;
  logic [2:0] count;
  logic       full;
  logic       empty;

  fifo_ctrl #(.wAddr(2), .wData(4)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .rf_wa0(rf_wa0), .rf_wd0(rf_wd0), .rf_we(rf_we),
    .rf_ra0(rf_ra0), .rf_rd0(rf_rd0),
    .count(count), .full(full), .empty(empty)
  );

  logic [3:0] rf_mem [4];
  always_ff @(posedge clock) if (rf_we) rf_mem[rf_wa0] <= rf_wd0;
  assign rf_rd0 = rf_mem[rf_ra0];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       fl;
    logic [3:0] d;
    int         cnt;
    logic       we;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         wp = 0;
  int         rp = 0;

  function automatic vec_t mk(logic iv, logic ordy, logic fl, logic [3:0] d, int cnt, logic we);
    vec_t v;
    v.iv = iv; v.ordy = ordy; v.fl = fl; v.d = d; v.cnt = cnt; v.we = we;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      n_err++;
    end
  endtask

  task automatic check_flags(int cnt, logic we);
    chk("count", 32'(count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == 4));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("in_ready", 32'(in_ready), 32'(cnt != 4));
    chk("out_valid", 32'(out_valid), 32'(cnt != 0));
    chk("rf_we", 32'(rf_we), 32'(we));
    chk("rf_wa0", 32'(rf_wa0), 32'(wp));
    chk("rf_ra0", 32'(rf_ra0), 32'(rp));
  endtask

  task automatic apply(vec_t v);
    logic [3:0] exp_d;
    @(negedge clock);
    in_valid  = v.iv;
    out_ready = v.ordy;
    flush     = v.fl;
    in_data   = v.d;
    #1;
    n_vec++;
    check_flags(v.cnt, v.we);
    if (v.we) chk("rf_wd0", 32'(rf_wd0), 32'(v.d));
    if (v.cnt != 0 && v.ordy && !v.fl) begin
      if (sb.size() == 0) begin
        $display("FAIL scoreboard: got pop with %0h expected no entry", out_data);
        n_err++;
      end else begin
        exp_d = sb.pop_front();
        chk("out_data", 32'(out_data), 32'(exp_d));
      end
      rp = (rp + 1) % 4;
    end
    if (v.we) begin
      sb.push_back(v.d);
      wp = (wp + 1) % 4;
    end
    if (v.fl) begin
      sb.delete();
      wp = 0;
      rp = 0;
    end
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;

    // idle after reset
    for (int i = 0; i < 3; i++) vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0));
    // fill to full, then refused pushes (one alongside a pop)
    vecs.push_back(mk(1, 0, 0, 4'h1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h2, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'h3, 2, 1));
    vecs.push_back(mk(1, 0, 0, 4'h4, 3, 1));
    vecs.push_back(mk(1, 0, 0, 4'h5, 4, 0));
    vecs.push_back(mk(1, 1, 0, 4'h6, 4, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 3, 0));
    // drain, then out_ready ignored while empty
    vecs.push_back(mk(0, 1, 0, 4'h0, 3, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 0, 0));
    // steady push+pop at count 2 across pointer wrap
    vecs.push_back(mk(1, 0, 0, 4'h8, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h9, 1, 1));
    for (int i = 0; i < 6; i++) vecs.push_back(mk(1, 1, 0, 4'(4'hA + i), 2, 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, 2, 0));
    vecs.push_back(mk(0, 1, 0, 4'h0, 1, 0));
    // flush at count 3 with concurrent push and pop
    vecs.push_back(mk(1, 0, 0, 4'h1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 4'h2, 1, 1));
    vecs.push_back(mk(1, 0, 0, 4'h3, 2, 1));
    vecs.push_back(mk(1, 1, 1, 4'h7, 3, 0));
    vecs.push_back(mk(1, 0, 0, 4'h5, 0, 1));
    vecs.push_back(mk(0, 1, 0, 4'h0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 4'h0, 0, 0));

    repeat (2) @(posedge clock);
    #1;
    n_vec++;
    check_flags(0, 0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // asynchronous reset between edges at count 2
    apply(mk(1, 0, 0, 4'h6, 0, 1));
    apply(mk(1, 0, 0, 4'h7, 1, 1));
    @(negedge clock);
    in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0; in_data = 4'h2;
    #1;
    n_vec++;
    chk("pre_reset_count", 32'(count), 32'd2);
    #1 reset = 1'b0;
    #1;
    sb.delete(); wp = 0; rp = 0;
    n_vec++;
    check_flags(0, 0);
    @(posedge clock);
    #1;
    n_vec++;
    check_flags(0, 0);
    @(negedge clock);
    reset = 1'b1; in_valid = 1'b0;
    apply(mk(1, 0, 0, 4'h9, 0, 1));
    apply(mk(1, 1, 0, 4'h3, 1, 1));
    apply(mk(0, 1, 0, 4'h0, 1, 0));
    apply(mk(0, 0, 0, 4'h0, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
